i2c_master_core: RTL and testbench
==================================

// Module: i2c_master_core
// PURPOSE
//   Single-byte, write-only I2C bus master. Generates the SCL clock and the SDA
//   data stream from the system clock: START, 8 data bits MSB-first, ACK slot, STOP.
//   Sits between a local controller (byte + active-low start request) and the I2C pads.
//   sda_out is the open-drain intent: 0 = pull low, 1 = release.
//   No slave response is sampled.
// PARAMETERS
//   CLK_DIV   2   clk cycles per SCL half-period (>=1); one SCL bit = 2*CLK_DIV clks
//   DATA_W    8   bits per transfer; must match the sda_in width
// PORTS
//   clk      in   1       system clock; all logic on the rising edge
//   rst      in   1       asynchronous, active-low reset
//   en       in   1       active-low start request (level-sampled, re-armed by going high)
//   sda_in   in   DATA_W  byte to transmit; captured when a transfer starts
//   SCL      out  1       I2C serial clock (registered)
//   sda_out  out  1       I2C serial data drive value (registered)
//   ack      out  1       high during the ACK bit slot of the frame
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, SCL=1, sda_out=1, ack=0, bit count=DATA_W-1,
//   divider=0, armed=1. Applies mid-frame immediately; no STOP is generated.
// - Divider: counts 0..CLK_DIV-1 in every non-IDLE phase; each phase is exactly CLK_DIV clks.
// - IDLE: SCL=1, sda_out=1, ack=0.
//   - If en=1: set armed=1.
//   - If en=0 and armed=1: latch sda_in into the shift register, clear armed, go to START.
//   - A held-low en therefore yields exactly one frame.
// - START: sda_out=0 while SCL=1 for CLK_DIV clks, then go to DATA.
// - DATA: per bit, MSB first, low phase then high phase:
//   - low phase: SCL=0 for CLK_DIV clks; sda_out = current bit, set on the first clk of the phase.
//   - high phase: SCL=1 for CLK_DIV clks; sda_out stable.
//   - After bit 0's high phase, go to ACK.
// - ACK: sda_out=1 (released) and ack=1 for the whole slot (CLK_DIV clks SCL=0,
//   then CLK_DIV clks SCL=1). Go to STOP.
// - STOP:
//   - SCL=0, sda_out=0 for CLK_DIV clks; then SCL=1, sda_out=0 for CLK_DIV clks.
//   - Then sda_out=1 and return to IDLE; the SDA rise occurs with SCL=1.
// - SDA never changes while SCL=1, except the START fall and the STOP rise.
// - sda_in changes after capture are ignored until the next frame.
// - en going high mid-frame does not abort the frame; it only re-arms.
// - Frame length = CLK_DIV*(2 + 4*(DATA_W+1)/2*... ) clks; concretely
//   CLK_DIV + 2*CLK_DIV*(DATA_W+1) + 2*CLK_DIV = 42 clks for the defaults.
// TESTING
// - rst=0 for 1 clk with en=1 -> SCL=1, sda_out=1, ack=0; stays idle while en=1.
// - en=0, sda_in=8'hAA -> START (sda_out falls, SCL=1).
//   - On SCL rising edges, sda_out reads 1,0,1,0,1,0,1,0; then ack=1 on the 9th SCL pulse; then STOP.
// - sda_in=8'h81; check MSB-first ordering and that the SDA transition occurs only while SCL=0.
// - Hold en=0 for 200 clks -> exactly one frame (42 clks); then pulse en=1 then 0 -> second frame.
// - Change sda_in to 8'h00 during the DATA phase of an 8'hFF frame -> all 8 bits still transmit 1.
// - Assert rst during bit 3 -> SCL=1, sda_out=1, ack=0 asynchronously; the next en=0 starts a fresh frame.

Source files
------------

// File: rtl/i2c_master_core_if.sv
// Local-controller and pad-side signals of the single-byte I2C write master.
// The master modport is the core's view; the slave modport is the controller/pad side.
interface i2c_master_core_if #(
  parameter int DATA_W = 8
);
  logic              en;
  logic [DATA_W-1:0] sda_in;
  logic              SCL;
  logic              sda_out;
  logic              ack;

  modport master (
    input  en,
    input  sda_in,
    output SCL,
    output sda_out,
    output ack
  );

  modport slave (
    output en,
    output sda_in,
    input  SCL,
    input  sda_out,
    input  ack
  );
endinterface

// File: rtl/i2c_master_core.sv
// Single-byte, write-only I2C master: START, DATA_W bits MSB-first, ACK slot, STOP.
// All pad outputs are registered and derived from the next state so every phase lasts CLK_DIV clks.
module i2c_master_core #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  i2c_master_core_if.master  bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA_LO,
    DATA_HI,
    ACK_LO,
    ACK_HI,
    STOP_LO,
    STOP_HI
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              armed_q, armed_d;
  logic              scl_q, scl_d;
  logic              sda_q, sda_d;
  logic              ack_q, ack_d;
  logic              phaseEnd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bitCnt_q <= CNT_TOP;
      shift_q  <= '0;
      armed_q  <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      armed_q  <= armed_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
      ack_q    <= ack_d;
    end
  end

  // en high re-arms at any time, so a mid-frame release never aborts the frame.
  always_comb begin
    state_d  = state_q;
    div_d    = '0;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    armed_d  = armed_q | bus.en;
    phaseEnd = (div_q == DIV_LAST);

    if (state_q != IDLE) begin
      div_d = phaseEnd ? '0 : div_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!bus.en && armed_q) begin
          shift_d = bus.sda_in;
          armed_d = 1'b0;
          state_d = START;
        end
      end
      START:   if (phaseEnd) state_d = DATA_LO;
      DATA_LO: if (phaseEnd) state_d = DATA_HI;
      DATA_HI: begin
        if (phaseEnd) begin
          if (bitCnt_q == '0) begin
            bitCnt_d = CNT_TOP;
            state_d  = ACK_LO;
          end else begin
            bitCnt_d = bitCnt_q - 1'b1;
            state_d  = DATA_LO;
          end
        end
      end
      ACK_LO:  if (phaseEnd) state_d = ACK_HI;
      ACK_HI:  if (phaseEnd) state_d = STOP_LO;
      STOP_LO: if (phaseEnd) state_d = STOP_HI;
      STOP_HI: if (phaseEnd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pad values follow the state being entered, so SDA settles on the first clk of a low phase.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    ack_d = 1'b0;
    case (state_d)
      START:   sda_d = 1'b0;
      DATA_LO: begin
        scl_d = 1'b0;
        sda_d = shift_d[bitCnt_d];
      end
      DATA_HI: sda_d = shift_d[bitCnt_d];
      ACK_LO: begin
        scl_d = 1'b0;
        ack_d = 1'b1;
      end
      ACK_HI:  ack_d = 1'b1;
      STOP_LO: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
      end
      STOP_HI: sda_d = 1'b0;
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        ack_d = 1'b0;
      end
    endcase
  end

  assign bus.SCL     = scl_q;
  assign bus.sda_out = sda_q;
  assign bus.ack     = ack_q;

endmodule

// File: tb/tb_i2c_master_core.sv
// Directed self-checking bench for i2c_master_core with default CLK_DIV=2, DATA_W=8.
// Frames are decoded from the pads: bits on SCL rising edges, ack slot, frame length, SDA-while-SCL-high events.
module tb_i2c_master_core;

  logic       clk;
  logic       rst;
  logic       enDrv;
  logic [7:0] sdaIn;
  int         assertCount;
  int         failCount;

  i2c_master_core_if #(.DATA_W(8)) bus ();

  assign bus.en     = enDrv;
  assign bus.sda_in = sdaIn;

  i2c_master_core #(
    .CLK_DIV(2),
    .DATA_W (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic enVal, input logic [7:0] data);
    @(negedge clk);
    enDrv = enVal;
    sdaIn = data;
  endtask

  // Decodes one frame starting from the first sample showing the START condition.
  // sdaIn is overwritten with swapData on SCL rising edge number swapAt (0 disables).
  task automatic captureFrame(input logic [7:0] swapData, input int swapAt,
                              output logic [7:0] bits, output int rising, output int ackAtNinth,
                              output int ackCnt, output int len, output int viol);
    logic prevScl;
    logic prevSda;
    bit   found;
    bits = '0; rising = 0; ackAtNinth = 0; ackCnt = 0; len = 0; viol = 0; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.SCL && !bus.sda_out) found = 1;
    end
    checkOutput("startSeen", 32'(found), 32'd1);
    if (!found) return;
    prevScl = 1'b1;
    prevSda = 1'b0;
    found   = 0;
    for (int i = 1; i < 200 && !found; i++) begin
      @(negedge clk);
      if (prevScl && bus.SCL && !prevSda && bus.sda_out) begin
        found = 1;
        len   = i;
      end else begin
        if (prevScl && bus.SCL && (prevSda != bus.sda_out)) viol++;
        if (!prevScl && bus.SCL) begin
          rising++;
          if (rising <= 8) bits = {bits[6:0], bus.sda_out};
          if (rising == 9) ackAtNinth = 32'(bus.ack);
          if (rising == swapAt) sdaIn = swapData;
        end
        if (bus.ack) ackCnt++;
      end
      prevScl = bus.SCL;
      prevSda = bus.sda_out;
    end
    checkOutput("stopSeen", 32'(found), 32'd1);
  endtask

  task automatic checkFrame(input string name, input logic [7:0] data, input logic [7:0] swapData,
                            input int swapAt);
    logic [7:0] bits;
    int rising, ackAtNinth, ackCnt, len, viol;
    captureFrame(swapData, swapAt, bits, rising, ackAtNinth, ackCnt, len, viol);
    checkOutput({name, ".bits"}, 32'(bits), 32'(data));
    checkOutput({name, ".ackNinth"}, 32'(ackAtNinth), 32'd1);
    checkOutput({name, ".ackClks"}, 32'(ackCnt), 32'd4);
    checkOutput({name, ".sclRises"}, 32'(rising), 32'd10);
    checkOutput({name, ".len"}, 32'(len), 32'd42);
    checkOutput({name, ".sdaWhileSclHigh"}, 32'(viol), 32'd0);
  endtask

  initial begin
    int busyCnt;
    bit found;
    assertCount = 0;
    failCount   = 0;
    enDrv = 1'b1;
    sdaIn = 8'h00;
    rst   = 1'b0;

    @(negedge clk);
    checkOutput("rst.SCL", 32'(bus.SCL), 32'd1);
    checkOutput("rst.sda", 32'(bus.sda_out), 32'd1);
    checkOutput("rst.ack", 32'(bus.ack), 32'd0);
    rst = 1'b1;

    busyCnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.SCL || !bus.sda_out || bus.ack) busyCnt++;
    end
    checkOutput("idleWhileEnHigh", 32'(busyCnt), 32'd0);

    $display("[TB] frame 0xAA, then en held low");
    applyStimulus(1'b0, 8'hAA);
    checkFrame("frameAA", 8'hAA, 8'h00, 0);
    busyCnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (!bus.SCL || !bus.sda_out || bus.ack) busyCnt++;
    end
    checkOutput("heldLowOneFrame", 32'(busyCnt), 32'd0);

    $display("[TB] re-arm, frame 0x81");
    applyStimulus(1'b1, 8'h81);
    applyStimulus(1'b1, 8'h81);
    applyStimulus(1'b0, 8'h81);
    checkFrame("frame81", 8'h81, 8'h00, 0);

    $display("[TB] frame 0xFF with sda_in changed mid-frame");
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b0, 8'hFF);
    checkFrame("frameFF", 8'hFF, 8'h00, 3);

    $display("[TB] reset during bit 3");
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h00);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.SCL && !bus.sda_out) found = 1;
    end
    checkOutput("midRst.startSeen", 32'(found), 32'd1);
    repeat (19) @(negedge clk);
    checkOutput("midRst.preScl", 32'(bus.SCL), 32'd0);
    checkOutput("midRst.preSda", 32'(bus.sda_out), 32'd0);
    #2 rst = 1'b0;
    #1;
    checkOutput("midRst.SCL", 32'(bus.SCL), 32'd1);
    checkOutput("midRst.sda", 32'(bus.sda_out), 32'd1);
    checkOutput("midRst.ack", 32'(bus.ack), 32'd0);
    enDrv = 1'b1;
    sdaIn = 8'h5A;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    busyCnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (!bus.SCL || !bus.sda_out || bus.ack) busyCnt++;
    end
    checkOutput("postRstIdle", 32'(busyCnt), 32'd0);
    applyStimulus(1'b0, 8'h5A);
    checkFrame("frame5A", 8'h5A, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
